laser_tx_scheduler: RTL and testbench

- Sequences the 5-slot outgoing message block (5 × 16 ASCII bytes, 640 bits) onto the laser byte transmitter.
- On a start request it snapshots the block, then emits one framed packet per enabled slot in slot order 0→4, with a valid/ready byte handshake toward the transmitter.
- Sits between the keyboard export/message memory and the laser TX serializer.

---
 rtl/laser_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_laser_tx_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_tx_scheduler.sv
// laser_tx_scheduler
// -----------------------------------------------------------------------------
// Sequences the 5-slot outgoing message block (5 x 16 ASCII bytes) onto the
// laser byte transmitter. A start request snapshots the block and slot mask.
// One framed packet is then sent for each enabled slot, in slot order 0 -> 4:
//   SYNC_BYTE, header {5'b0, slot}, 16 payload bytes (first-typed char first),
//   [checksum byte], then GAP_CYCLES idle clocks.
//
// Optional feature macro: LASER_TX_CHECKSUM_EN
//   defined   : a CSUM byte (XOR of header and 16 payload bytes) follows PAY
//   undefined : no CSUM state and no checksum logic; frames are 18 bytes
//
// Ports:
//   clock_65mhz  in   system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle transmit request (ignored while busy)
//   abort        in   level; cancels the run, back to IDLE next cycle
//   slot_mask    in   [4:0] bit i enables slot i, sampled with start
//   messageout   in   [639:0] message block, slot i = bits [128*i+127:128*i]
//   tx_data      out  [7:0] byte to transmitter
//   tx_valid     out  tx_data valid
//   tx_ready     in   transmitter accepts the byte this cycle
//   busy         out  run in progress (SEL .. GAP)
//   done         out  one-cycle pulse when all enabled frames completed
//   cur_slot     out  [2:0] slot currently being framed
//   frames_sent  out  [2:0] frames completed in the current run
//   state_dbg    out  [2:0] FSM state encoding, for observation only
//
// Handshake: a byte transfers on a clock edge where tx_valid & tx_ready is
// high. While tx_valid is high and no transfer has happened, tx_data is held
// stable; tx_valid only drops after a transfer, or on abort/reset. tx_valid
// and tx_data are decoded from registers only, so there is no combinational
// path from tx_ready to either of them.
// -----------------------------------------------------------------------------
module laser_tx_scheduler #(
  parameter logic [7:0] SYNC_BYTE  = 8'h7E,
  parameter int         GAP_CYCLES = 16,
  parameter int         GAP_W      = 8
) (
  input  logic         clock_65mhz,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [4:0]   slot_mask,
  input  logic [639:0] messageout,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done,
  output logic [2:0]   cur_slot,
  output logic [2:0]   frames_sent,
  output logic [2:0]   state_dbg
);

`ifdef LASER_TX_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_SYNC = 3'd2,
    S_HDR  = 3'd3,
    S_PAY  = 3'd4,
    S_GAP  = 3'd5,
    S_FIN  = 3'd6,
    S_CSUM = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_SYNC = 3'd2,
    S_HDR  = 3'd3,
    S_PAY  = 3'd4,
    S_GAP  = 3'd5,
    S_FIN  = 3'd6
  } state_t;
`endif

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t         state_q, state_d;
  logic [639:0]   snap_q, snap_d;
  logic [4:0]     mask_q, mask_d;
  logic [2:0]     slot_q, slot_d;
  logic [2:0]     frames_q, frames_d;
  logic [3:0]     k_q, k_d;
  logic [GAP_W-1:0] gap_q, gap_d;
`ifdef LASER_TX_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic       accept_start;
  logic       xfer;          // byte really leaves this cycle (abort wins)
  logic       frame_last;    // last byte of the frame leaves this cycle
  logic       sel_found;
  logic [2:0] sel_slot;
  logic [9:0] pay_idx;
  logic [7:0] hdr_byte;

  assign accept_start = (state_q == S_IDLE) && start && !abort;
  assign xfer         = tx_valid && tx_ready && !abort;
  assign hdr_byte     = {5'b00000, slot_q};
  // Bit offset of payload byte k of the current slot: 128*slot + 8*k.
  assign pay_idx      = {slot_q, k_q, 3'b000};

`ifdef LASER_TX_CHECKSUM_EN
  assign frame_last = xfer && (state_q == S_CSUM);
`else
  assign frame_last = xfer && (state_q == S_PAY) && (k_q == 4'd0);
`endif

  // Lowest enabled slot that has not been sent yet.
  always_comb begin
    sel_found = 1'b0;
    sel_slot  = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_found = 1'b1;
        sel_slot  = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept_start) state_d = S_SEL;
        S_SEL:  state_d = sel_found ? S_SYNC : S_FIN;
        S_SYNC: if (xfer) state_d = S_HDR;
        S_HDR:  if (xfer) state_d = S_PAY;
`ifdef LASER_TX_CHECKSUM_EN
        S_PAY:  if (xfer && (k_q == 4'd0)) state_d = S_CSUM;
        S_CSUM: if (xfer) state_d = S_GAP;
`else
        S_PAY:  if (xfer && (k_q == 4'd0)) state_d = S_GAP;
`endif
        S_GAP:  if (gap_q == GAP_LAST) state_d = S_SEL;
        S_FIN:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    done     = (state_q == S_FIN);
    case (state_q)
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
      end
      S_PAY: begin
        tx_valid = 1'b1;
        tx_data  = snap_q[pay_idx +: 8];
      end
`ifdef LASER_TX_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  assign cur_slot    = slot_q;
  assign frames_sent = frames_q;
  assign state_dbg   = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    snap_d   = snap_q;
    mask_d   = mask_q;
    slot_d   = slot_q;
    frames_d = frames_q;
    k_d      = k_q;
    gap_d    = gap_q;
`ifdef LASER_TX_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // Snapshot taken only in the accepting cycle; later edits to the live
    // message block cannot leak into a run in progress.
    if (accept_start) begin
      snap_d   = messageout;
      mask_d   = slot_mask;
      frames_d = 3'd0;
    end

    if ((state_q == S_SEL) && sel_found) begin
      slot_d = sel_slot;
    end

    if ((state_q == S_HDR) && xfer) begin
      k_d = 4'd15;
`ifdef LASER_TX_CHECKSUM_EN
      csum_d = hdr_byte;
`endif
    end

    if ((state_q == S_PAY) && xfer) begin
      k_d = k_q - 4'd1;
`ifdef LASER_TX_CHECKSUM_EN
      csum_d = csum_q ^ tx_data;
`endif
    end

    if (frame_last) begin
      mask_d   = mask_q & ~(5'b00001 << slot_q);
      frames_d = frames_q + 3'd1;
      gap_d    = '0;
    end

    if (state_q == S_GAP) begin
      gap_d = gap_q + GAP_ONE;
    end
  end

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      snap_q   <= '0;
      mask_q   <= '0;
      slot_q   <= '0;
      frames_q <= '0;
      k_q      <= '0;
      gap_q    <= '0;
`ifdef LASER_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      snap_q   <= snap_d;
      mask_q   <= mask_d;
      slot_q   <= slot_d;
      frames_q <= frames_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
`ifdef LASER_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// tb_laser_tx_scheduler
// Directed bench for laser_tx_scheduler: a cycle table for the first frame,
// then hand-written sequences for multi-slot runs, back-pressure with a
// changing message block, abort, empty mask and reset mid-frame.
module tb_laser_tx_scheduler;

  localparam int GAP = 16;
`ifdef LASER_TX_CHECKSUM_EN
  localparam int FL = 19;
`else
  localparam int FL = 18;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [4:0]   slot_mask;
  logic [639:0] messageout;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;
  logic [2:0]   cur_slot;
  logic [2:0]   frames_sent;
  logic [2:0]   state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  laser_tx_scheduler dut (
    .clock_65mhz (clk),
    .reset_n     (rst_n),
    .start       (start),
    .abort       (abort),
    .slot_mask   (slot_mask),
    .messageout  (messageout),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .cur_slot    (cur_slot),
    .frames_sent (frames_sent),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  logic [2:0] rx_slot_q[$];

  int done_count = 0;
  int done_cyc   = 0;
  int valid_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [127:0] str_slot(input string s);
    logic [127:0] r;
    logic [7:0]   c;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      c = (k < s.len()) ? s[k] : 8'h20;
      r[127 - 8*k -: 8] = c;
    end
    return r;
  endfunction

  function automatic logic [639:0] rand_block();
    logic [639:0] r;
    for (int w = 0; w < 20; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  // Expected frame: sync, header, payload first-typed first, optional XOR.
  function automatic void push_frame(input int slot, input logic [639:0] snap);
    logic [7:0] b;
    logic [7:0] cs;
    exp_q.push_back(8'h7E);
    cs = 8'(slot);
    exp_q.push_back(8'(slot));
    for (int k = 15; k >= 0; k--) begin
      b = snap[128*slot + 8*k +: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef LASER_TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  task automatic check_stream(input string name);
    chk({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk({name, "_byte"}, rx_q[i], exp_q[i]);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rx_q.delete();
    rx_cyc_q.delete();
    rx_slot_q.delete();
  endtask

  // Monitor on the falling edge: what is presented now transfers at the next
  // rising edge. Also checks that a stalled byte is held until accepted.
  logic       hold;
  logic [7:0] hold_data;
  initial hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_data});
      if (tx_valid && tx_ready && !abort) begin
        rx_q.push_back(tx_data);
        rx_cyc_q.push_back(cyc);
        rx_slot_q.push_back(cur_slot);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (tx_valid) valid_seen++;
      hold      = tx_valid && !tx_ready && !abort;
      hold_data = tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int prev, input int budget);
    int n = 0;
    while (done_count == prev && n < budget) begin
      tick();
      n++;
    end
    if (done_count == prev) chk({name, "_timeout"}, done_count, prev + 1);
  endtask

  task automatic wait_rx(input string name, input int count, input int budget);
    int n = 0;
    while (rx_q.size() < count && n < budget) begin
      tick();
      n++;
    end
    if (rx_q.size() < count) chk({name, "_timeout"}, rx_q.size(), count);
  endtask

  // ---------------------------------------------------------------------------
  // Table for the first frame: one row per cycle from the start cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tbl[0:2+FL-1];
  logic [7:0] hello_b[16];

  initial begin : main
    logic [639:0] snap;
    logic [7:0]   cs;
    int           dc;
    int           vs;
    int           start_cyc;
    int           gap_len;

    hello_b = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
                8'h52, 8'h4C, 8'h44, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00};   // start cycle, still IDLE
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00};   // SEL
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h7E};   // SYNC
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h00};   // header, slot 0
    cs = 8'h00;
    for (int k = 0; k < 16; k++) begin
      tbl[4+k] = '{1'b1, 1'b1, 1'b0, hello_b[k]};
      cs = cs ^ hello_b[k];
    end
`ifdef LASER_TX_CHECKSUM_EN
    tbl[20] = '{1'b1, 1'b1, 1'b0, cs};
`endif

    // Reset state
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; slot_mask = '0;
    messageout = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cur_slot", cur_slot, 3'd0);
    chk("rst_frames", frames_sent, 3'd0);
    rst_n = 1'b1;
    tick();

    // HELLO WORLD in slot 0, tx_ready held high, cycle-exact table
    clear_sb();
    tx_ready   = 1'b1;
    messageout = '0;
    messageout[127:0] = str_slot("HELLO WORLD     ");
    snap = messageout;
    dc = done_count;
    start = 1'b1; slot_mask = 5'b00001; start_cyc = cyc;
    for (int i = 0; i < 2 + FL; i++) begin
      @(negedge clk);
      chk("tbl_valid", tx_valid, tbl[i].exp_valid);
      chk("tbl_busy", busy, tbl[i].exp_busy);
      chk("tbl_done", done, tbl[i].exp_done);
      if (tbl[i].exp_valid) chk("tbl_data", tx_data, tbl[i].exp_data);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done("hello", dc, 200);
    chk("hello_done_cycle", done_cyc, start_cyc + 2 + FL + GAP + 1);
    chk("hello_done_once", done_count, dc + 1);
    chk("hello_done_pulse", done, 1'b0);
    chk("hello_busy_after", busy, 1'b0);
    chk("hello_frames", frames_sent, 3'd1);
    push_frame(0, snap);
    check_stream("hello");

    // Slots 2 and 4, blank text
    clear_sb();
    for (int s = 0; s < 5; s++) messageout[128*s +: 128] = str_slot("[     blank    ]");
    snap = messageout;
    dc = done_count;
    start = 1'b1; slot_mask = 5'b10100;
    tick();
    start = 1'b0;
    wait_done("blank", dc, 400);
    repeat (2) tick();
    chk("blank_done_once", done_count, dc + 1);
    chk("blank_frames", frames_sent, 3'd2);
    push_frame(2, snap);
    push_frame(4, snap);
    check_stream("blank");
    if (rx_q.size() == 2 * FL) begin
      chk("blank_slot_first", rx_slot_q[0], 3'd2);
      chk("blank_slot_second", rx_slot_q[FL], 3'd4);
      gap_len = rx_cyc_q[FL] - rx_cyc_q[FL-1] - 1;
      chk("blank_gap_min", 32'(gap_len >= GAP), 32'd1);
    end

    // Random back-pressure while messageout changes every cycle
    clear_sb();
    messageout = rand_block();
    snap = messageout;
    dc = done_count;
    tx_ready = 1'($urandom_range(0, 1));
    start = 1'b1; slot_mask = 5'b01011;
    tick();
    start = 1'b0;
    for (int n = 0; n < 3000 && done_count == dc; n++) begin
      tx_ready   = 1'($urandom_range(0, 1));
      messageout = rand_block();
      tick();
    end
    chk("rand_done", done_count, dc + 1);
    chk("rand_frames", frames_sent, 3'd3);
    push_frame(0, snap);
    push_frame(1, snap);
    push_frame(3, snap);
    check_stream("rand");

    // Abort during payload byte 5 of slot 1, then a clean restart
    clear_sb();
    tx_ready = 1'b1;
    messageout = rand_block();
    snap = messageout;
    dc = done_count;
    start = 1'b1; slot_mask = 5'b00011;
    tick();
    start = 1'b0;
    wait_rx("abort_reach", FL + 2 + 5, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", tx_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_frames_kept", frames_sent, 3'd1);
    push_frame(0, snap);
    push_frame(1, snap);
    while (exp_q.size() > FL + 7) void'(exp_q.pop_back());
    check_stream("abort");
    repeat (GAP + 5) tick();
    chk("abort_no_done", done_count, dc);
    clear_sb();
    start = 1'b1; slot_mask = 5'b00001;
    tick();
    start = 1'b0;
    chk("restart_frames_clr", frames_sent, 3'd0);
    chk("restart_busy", busy, 1'b1);
    wait_done("restart", dc, 200);
    tick();
    chk("restart_frames", frames_sent, 3'd1);
    push_frame(0, snap);
    check_stream("restart");

    // Empty mask, plus a second start while busy
    dc = done_count;
    vs = valid_seen;
    start = 1'b1; slot_mask = 5'b00000;
    tick();                               // N+1
    chk("empty_busy_n1", busy, 1'b1);
    chk("empty_done_n1", done, 1'b0);
    start = 1'b1; slot_mask = 5'b11111;   // ignored: already busy
    tick();                               // N+2
    start = 1'b0;
    chk("empty_done_n2", done, 1'b1);
    chk("empty_busy_n2", busy, 1'b0);
    tick();                               // N+3
    chk("empty_done_n3", done, 1'b0);
    chk("empty_busy_n3", busy, 1'b0);
    repeat (5) tick();
    chk("empty_done_once", done_count, dc + 1);
    chk("empty_no_valid", valid_seen, vs);

    // Reset in the middle of the second frame
    clear_sb();
    messageout = rand_block();
    start = 1'b1; slot_mask = 5'b00011;
    tick();
    start = 1'b0;
    wait_rx("rstmid_reach", FL + 3, 200);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", tx_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_frames", frames_sent, 3'd0);
    chk("rstmid_cur_slot", cur_slot, 3'd0);
    chk("rstmid_data", tx_data, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dc = done_count;
    vs = valid_seen;
    repeat (40) tick();
    chk("rstmid_no_done", done_count, dc);
    chk("rstmid_no_valid", valid_seen, vs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
